// File: rtl/gpio_mailbox_pkg.sv
// Shared types and GPIO bit positions for the GPIO mailbox.
// Holds no logic, so it has no latency. It has no backpressure role either.
package gpio_mailbox_pkg;

  typedef enum logic {
    P_IDLE,
    P_PRESENT
  } pres_state_t;

  // cpu_io1 (status word seen by the CPU)
  localparam int IO1_RX_TOG     = 0;
  localparam int IO1_TX_ACK     = 1;
  localparam int IO1_IN_NE      = 2;
  localparam int IO1_OUT_FULL   = 3;
  localparam int IO1_INCNT_LSB  = 8;
  localparam int IO1_OUTCNT_LSB = 16;

  // cpu_io3 (control word written by the CPU)
  localparam int IO3_TX_TOG  = 0;
  localparam int IO3_RX_ACK  = 1;
  localparam int IO3_LINK_EN = 31;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  function automatic logic toggle_pending(input logic link_en, input logic tog, input logic seen);
    return link_en && (tog != seen);
  endfunction

endpackage

// File: rtl/mailbox_fifo.sv
// Synchronous 32-bit FIFO with occupancy count. Head is valid in the cycle after a push into an empty FIFO.
// A push while full and a pop while empty are dropped. head reads 0 while empty.
module mailbox_fifo
  import gpio_mailbox_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // Simultaneous push and pop leave occupancy unchanged.
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/gpio_mailbox.sv
// Toggle-handshake mailbox between a host valid/ready stream and CPU GPIO words (count fields under GPIO_MAILBOX_COUNT_EN).
// Latency: a word is presented one edge after it is pushed, and pushed out one edge after a CPU tx toggle.
// Backpressure: h_in_ready drops when inbound is full. A tx toggle stays pending while outbound is full.
module gpio_mailbox
  import gpio_mailbox_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] h_in_data,
  input  logic              h_in_valid,
  output logic              h_in_ready,
  output logic [DATA_W-1:0] h_out_data,
  output logic              h_out_valid,
  input  logic              h_out_ready,
  output logic [DATA_W-1:0] cpu_io0,
  output logic [DATA_W-1:0] cpu_io1,
  input  logic [DATA_W-1:0] cpu_io2,
  input  logic [DATA_W-1:0] cpu_io3
);

  pres_state_t       state_q, state_d;
  logic [DATA_W-1:0] io0_q, io0_d;
  logic              rx_tog_q, rx_tog_d;
  logic              ack_seen_q, ack_seen_d;
  logic              tx_seen_q, tx_seen_d;

  logic              in_full, in_empty, in_pop, in_push;
  logic [AW:0]       in_count;
  logic [DATA_W-1:0] in_head;
  logic              out_full, out_empty, out_pop, out_push;
  logic [AW:0]       out_count;
  logic              link_en;
  logic              unused_io3;

  assign link_en    = cpu_io3[IO3_LINK_EN];
  assign unused_io3 = ^cpu_io3[30:2];

  assign h_in_ready  = !in_full;
  assign in_push     = h_in_valid && h_in_ready;
  assign h_out_valid = !out_empty;
  assign out_pop     = h_out_valid && h_out_ready;

  mailbox_fifo #(.DEPTH(DEPTH)) u_in_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_push),
    .push_data (h_in_data),
    .pop       (in_pop),
    .full      (in_full),
    .empty     (in_empty),
    .count     (in_count),
    .head      (in_head)
  );

  mailbox_fifo #(.DEPTH(DEPTH)) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (out_push),
    .push_data (cpu_io2),
    .pop       (out_pop),
    .full      (out_full),
    .empty     (out_empty),
    .count     (out_count),
    .head      (h_out_data)
  );

  // Presenter: one word at a time, released by an rx_ack toggle from the CPU.
  always_comb begin
    state_d    = state_q;
    io0_d      = io0_q;
    rx_tog_d   = rx_tog_q;
    ack_seen_d = ack_seen_q;
    in_pop     = 1'b0;
    case (state_q)
      P_IDLE: begin
        if (!in_empty) begin
          in_pop   = 1'b1;
          io0_d    = in_head;
          rx_tog_d = !rx_tog_q;
          state_d  = P_PRESENT;
        end
      end
      P_PRESENT: begin
        if (toggle_pending(link_en, cpu_io3[IO3_RX_ACK], ack_seen_q)) begin
          ack_seen_d = cpu_io3[IO3_RX_ACK];
          state_d    = P_IDLE;
        end
      end
      default: state_d = P_IDLE;
    endcase
  end

  // Outbound capture: a tx toggle is taken only when there is room, otherwise it stays pending.
  always_comb begin
    out_push  = 1'b0;
    tx_seen_d = tx_seen_q;
    if (toggle_pending(link_en, cpu_io3[IO3_TX_TOG], tx_seen_q) && !out_full) begin
      out_push  = 1'b1;
      tx_seen_d = cpu_io3[IO3_TX_TOG];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= P_IDLE;
      io0_q      <= '0;
      rx_tog_q   <= 1'b0;
      ack_seen_q <= 1'b0;
      tx_seen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      io0_q      <= io0_d;
      rx_tog_q   <= rx_tog_d;
      ack_seen_q <= ack_seen_d;
      tx_seen_q  <= tx_seen_d;
    end
  end

`ifdef GPIO_MAILBOX_COUNT_EN
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  always_comb begin
    in_cnt_d  = CNT_W'(in_count);
    out_cnt_d = CNT_W'(out_count);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^{in_count, out_count};
`endif

  always_comb begin
    cpu_io1               = '0;
    cpu_io1[IO1_RX_TOG]   = rx_tog_q;
    cpu_io1[IO1_TX_ACK]   = tx_seen_q;
    cpu_io1[IO1_IN_NE]    = !in_empty;
    cpu_io1[IO1_OUT_FULL] = out_full;
`ifdef GPIO_MAILBOX_COUNT_EN
    cpu_io1[IO1_INCNT_LSB +: CNT_W]  = in_cnt_q;
    cpu_io1[IO1_OUTCNT_LSB +: CNT_W] = out_cnt_q;
`endif
  end

  assign cpu_io0 = io0_q;

endmodule

// File: tb/tb_gpio_mailbox.sv
// Directed bench for gpio_mailbox (DEPTH=4): presenter handshake, outbound toggles, FIFO full/wrap, async reset.
// Build with GPIO_MAILBOX_COUNT_EN defined to also cover the occupancy fields.
module tb_gpio_mailbox;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] h_in_data;
  logic        h_in_valid;
  logic        h_in_ready;
  logic [31:0] h_out_data;
  logic        h_out_valid;
  logic        h_out_ready;
  logic [31:0] cpu_io0;
  logic [31:0] cpu_io1;
  logic [31:0] cpu_io2;
  logic [31:0] cpu_io3;

  gpio_mailbox #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .h_in_data   (h_in_data),
    .h_in_valid  (h_in_valid),
    .h_in_ready  (h_in_ready),
    .h_out_data  (h_out_data),
    .h_out_valid (h_out_valid),
    .h_out_ready (h_out_ready),
    .cpu_io0     (cpu_io0),
    .cpu_io1     (cpu_io1),
    .cpu_io2     (cpu_io2),
    .cpu_io3     (cpu_io3)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] words [6];
  int          s_idx    = 0;
  bit          stream_on = 1'b0;
  logic        tog;
  logic        rx_ack;
  logic        prev;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // One clock; inputs change 1 time unit after the edge. Streams words[] when enabled.
  task automatic tick();
    bit acc;
    acc = (h_in_valid === 1'b1) && (h_in_ready === 1'b1);
    @(posedge clk);
    #1;
    if (stream_on && acc) begin
      s_idx++;
      if (s_idx < 6) h_in_data = words[s_idx];
      else h_in_valid = 1'b0;
    end
  endtask

  task automatic host_push(input logic [31:0] w);
    h_in_data  = w;
    h_in_valid = 1'b1;
    tick();
    h_in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    cpu_io3     = 'x;
    cpu_io2     = '0;
    h_in_valid  = 1'b1;
    h_in_data   = 32'hFFFF_FFFF;
    h_out_ready = 1'b0;
    for (int i = 0; i < 6; i++) words[i] = 32'h1000_0000 + 32'(i * 17);

    // Reset state, with h_in_valid asserted during reset
    #12;
    check32("rst_io0", cpu_io0, 32'h0);
    check32("rst_io1", cpu_io1, 32'h0);
    check32("rst_out_valid", {31'b0, h_out_valid}, 32'h0);
    check32("rst_in_ready", {31'b0, h_in_ready}, 32'h1);
    @(negedge clk);
    rst_n      = 1'b1;
    h_in_valid = 1'b0;
    tick();
    check32("rst_valid_ignored", cpu_io1 & 32'hFF, 32'h0);

    // Presentation latency, and holding while link_en is not 1
    host_push(32'h1234_5678);
    check32("pres_not_yet", cpu_io0, 32'h0);
    check32("pres_in_ne", cpu_io1 & 32'hFF, 32'h4);
    tick();
    check32("pres_io0", cpu_io0, 32'h1234_5678);
    check32("pres_io1", cpu_io1 & 32'hFF, 32'h1);
    host_push(32'hDEAD_BEEF);
    check32("queued_io1", cpu_io1 & 32'hFF, 32'h5);
    cpu_io3 = 32'h0000_0002;
    repeat (3) tick();
    check32("no_ack_link_off", cpu_io0, 32'h1234_5678);
    check32("no_ack_rx_tog", {31'b0, cpu_io1[0]}, 32'h1);

    // Ack returns to idle; next word appears two edges after the io3 change
    cpu_io3 = 32'h8000_0000;
    tick();
    cpu_io3 = 32'h8000_0002;
    tick();
    check32("ack_hold_1edge", cpu_io0, 32'h1234_5678);
    tick();
    check32("ack_next_io0", cpu_io0, 32'hDEAD_BEEF);
    check32("ack_next_io1", cpu_io1 & 32'hFF, 32'h0);

    // Outbound single toggle (also acks DEADBEEF)
    cpu_io2 = 32'hA5A5_0001;
    tick();
    cpu_io3 = 32'h8000_0001;
    tick();
    check32("tx_valid", {31'b0, h_out_valid}, 32'h1);
    check32("tx_data", h_out_data, 32'hA5A5_0001);
    check32("tx_io1", cpu_io1 & 32'hFF, 32'h2);
    repeat (3) tick();
    h_out_ready = 1'b1;
    tick();
    h_out_ready = 1'b0;
    check32("tx_no_dup", {31'b0, h_out_valid}, 32'h0);
    check32("tx_io0_held", cpu_io0, 32'hDEAD_BEEF);

    // Five toggles into a DEPTH=4 outbound FIFO
    tog = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tog     = ~tog;
      cpu_io2 = 32'hB000_0000 + 32'(k);
      tick();
      cpu_io3 = 32'h8000_0000 | {31'b0, tog};
      tick();
      tick();
    end
    check32("full_flag", {31'b0, cpu_io1[3]}, 32'h1);
    check32("full_pending_ack", {31'b0, cpu_io1[1]}, 32'h1);
    check32("full_head", h_out_data, 32'hB000_0000);
    h_out_ready = 1'b1;
    tick();
    h_out_ready = 1'b0;
    check32("pop_not_full", {31'b0, cpu_io1[3]}, 32'h0);
    check32("pop_still_pending", {31'b0, cpu_io1[1]}, 32'h1);
    tick();
    check32("pending_entered", {31'b0, cpu_io1[1]}, 32'h0);
    check32("refull_flag", {31'b0, cpu_io1[3]}, 32'h1);
    for (int k = 1; k < 5; k++) begin
      check32($sformatf("drain_%0d", k), h_out_data, 32'hB000_0000 + 32'(k));
      h_out_ready = 1'b1;
      tick();
      h_out_ready = 1'b0;
    end
    check32("drained", {31'b0, h_out_valid}, 32'h0);

    // Host streams 6 words into DEPTH=4 inbound FIFO; presenter acks one at a time
    cpu_io3    = 32'h8000_0000;
    rx_ack     = 1'b0;
    s_idx      = 0;
    stream_on  = 1'b1;
    h_in_data  = words[0];
    h_in_valid = 1'b1;
    repeat (8) tick();
    check32("stream_accepted5", 32'(s_idx), 32'd5);
    check32("stream_in_full", {31'b0, h_in_ready}, 32'h0);
    check32("stream_first", cpu_io0, words[0]);
`ifdef GPIO_MAILBOX_COUNT_EN
    check32("cnt_in_full", {24'b0, cpu_io1[15:8]}, 32'd4);
    check32("cnt_out_empty", {24'b0, cpu_io1[23:16]}, 32'd0);
`endif
    for (int k = 1; k < 6; k++) begin
      rx_ack  = ~rx_ack;
      cpu_io3 = 32'h8000_0000 | {30'b0, rx_ack, 1'b0};
      prev    = cpu_io1[0];
      for (int c = 0; c < 10 && cpu_io1[0] == prev; c++) tick();
      check32($sformatf("stream_word_%0d", k), cpu_io0, words[k]);
    end
    check32("stream_accepted6", 32'(s_idx), 32'd6);
    check32("stream_in_empty", {31'b0, cpu_io1[2]}, 32'h0);
    stream_on = 1'b0;

    // Asynchronous reset between edges with traffic in flight
    host_push(32'h7777_7777);
    cpu_io2 = 32'hC0DE_0001;
    tick();
    cpu_io3 = 32'h8000_0003;
    tick();
    check32("pre_rst_out_valid", {31'b0, h_out_valid}, 32'h1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check32("arst_io0", cpu_io0, 32'h0);
    check32("arst_io1", cpu_io1, 32'h0);
    check32("arst_out_valid", {31'b0, h_out_valid}, 32'h0);
    check32("arst_out_data", h_out_data, 32'h0);
    cpu_io3 = 32'h8000_0000;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check32("post_rst_io1", cpu_io1, 32'h0);
    check32("post_rst_io0", cpu_io0, 32'h0);
    check32("post_rst_out_valid", {31'b0, h_out_valid}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
